sprite_fetch: RTL and testbench

SPRITE_FETCH -- requirements
Module: sprite_fetch

---
 rtl/sprite_fetch.sv | 128 ++++++++++++
 tb/tb_sprite_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch.sv
// Sprite fetch: 3-stage pipeline that tests each pixel against an animated sprite box,
// addresses an external synchronous ROM and colour-keys the returned word.
module sprite_fetch #(
  parameter int                WIDTH    = 12,
  parameter int                SPR_W    = 32,
  parameter int                SPR_H    = 32,
  parameter int                FRAMES   = 4,
  parameter int                ANIM_DIV = 8,
  parameter int                COORD_W  = 10,
  parameter logic [WIDTH-1:0]  TRANSP   = 12'h000,
  localparam int               AWIDTH   = $clog2(SPR_W*SPR_H*FRAMES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [COORD_W-1:0]  pix_x,
  input  logic [COORD_W-1:0]  pix_y,
  input  logic                de_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic [COORD_W-1:0]  pos_x,
  input  logic [COORD_W-1:0]  pos_y,
  input  logic                pos_we,
  input  logic                anim_en,
  output logic                rom_en,
  output logic [AWIDTH-1:0]   rom_addr,
  input  logic [WIDTH-1:0]    rom_data,
  output logic [WIDTH-1:0]    rgb_out,
  output logic                hit_out,
  output logic                de_out,
  output logic                hsync_out,
  output logic                vsync_out
);

  localparam int IDXW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DIVW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic                vs_q;
  logic [COORD_W-1:0]  pend_x_q, pend_y_q, act_x_q, act_y_q;
  logic [DIVW-1:0]     div_q;
  logic [IDXW-1:0]     idx_q;
  logic                rom_en_q, en2_q, hit_q;
  logic [AWIDTH-1:0]   rom_addr_q;
  logic [WIDTH-1:0]    rgb_q;
  logic [2:0]          de_sr_q, hs_sr_q, vs_sr_q;

  logic                frame_start_d;
  logic                in_box_d;
  logic [COORD_W:0]    x_end_d, y_end_d;
  logic [COORD_W-1:0]  dx_d, dy_d;
  logic [AWIDTH-1:0]   rom_addr_d;
  logic                opaque_d;

  assign frame_start_d = vsync_in & ~vs_q;

  // Box limits carry one extra bit so a sprite hanging off the raster clips instead of wrapping.
  assign x_end_d  = {1'b0, act_x_q} + (COORD_W+1)'(SPR_W);
  assign y_end_d  = {1'b0, act_y_q} + (COORD_W+1)'(SPR_H);
  assign in_box_d = de_in && (pix_x >= act_x_q) && ({1'b0, pix_x} < x_end_d)
                          && (pix_y >= act_y_q) && ({1'b0, pix_y} < y_end_d);
  assign dx_d     = pix_x - act_x_q;
  assign dy_d     = pix_y - act_y_q;
  assign rom_addr_d = in_box_d
                    ? AWIDTH'(idx_q) * AWIDTH'(SPR_W*SPR_H) + AWIDTH'(dy_d) * AWIDTH'(SPR_W) + AWIDTH'(dx_d)
                    : '0;
  assign opaque_d = en2_q && (rom_data != TRANSP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= 1'b0;
      pend_x_q <= '0;
      pend_y_q <= '0;
      act_x_q  <= '0;
      act_y_q  <= '0;
      div_q    <= '0;
      idx_q    <= '0;
    end else begin
      vs_q <= vsync_in;
      if (pos_we) begin
        pend_x_q <= pos_x;
        pend_y_q <= pos_y;
      end
      // A write landing on the frame-start cycle takes effect for that frame.
      if (frame_start_d) begin
        act_x_q <= pos_we ? pos_x : pend_x_q;
        act_y_q <= pos_we ? pos_y : pend_y_q;
        if (anim_en) begin
          if (div_q == DIVW'(ANIM_DIV-1)) begin
            div_q <= '0;
            idx_q <= (idx_q == IDXW'(FRAMES-1)) ? '0 : idx_q + 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      en2_q      <= 1'b0;
      hit_q      <= 1'b0;
      rgb_q      <= '0;
      de_sr_q    <= '0;
      hs_sr_q    <= '0;
      vs_sr_q    <= '0;
    end else begin
      rom_en_q   <= in_box_d;
      rom_addr_q <= rom_addr_d;
      en2_q      <= rom_en_q;
      hit_q      <= opaque_d;
      rgb_q      <= opaque_d ? rom_data : '0;
      de_sr_q    <= {de_sr_q[1:0], de_in};
      hs_sr_q    <= {hs_sr_q[1:0], hsync_in};
      vs_sr_q    <= {vs_sr_q[1:0], vsync_in};
    end
  end

  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign hit_out   = hit_q;
  assign rgb_out   = rgb_q;
  assign de_out    = de_sr_q[2];
  assign hsync_out = hs_sr_q[2];
  assign vsync_out = vs_sr_q[2];

endmodule

// File: tb/tb_sprite_fetch.sv
// Bench for sprite_fetch: directed and random pixels against a per-pixel reference model
// plus a synchronous ROM model.
module tb_sprite_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0, pos_x = '0, pos_y = '0;
  logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, pos_we = 1'b0, anim_en = 1'b0;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [11:0] rgb_out;
  logic        hit_out, de_out, hsync_out, vsync_out;

  logic [11:0] mem [0:4095];

  sprite_fetch dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pos_x(pos_x), .pos_y(pos_y),
    .pos_we(pos_we), .anim_en(anim_en), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .rgb_out(rgb_out), .hit_out(hit_out), .de_out(de_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom_en ? mem[rom_addr] : 12'h000;

  typedef struct {
    bit inb;
    int addr;
    bit de;
    bit hs;
    bit vs;
  } h_t;

  h_t hist[$];
  int m_pend_x, m_pend_y, m_act_x, m_act_y, m_fs_cnt;
  bit m_prev_vs;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    h_t z;
    z = '{inb: 0, addr: 0, de: 0, hs: 0, vs: 0};
    m_pend_x = 0; m_pend_y = 0; m_act_x = 0; m_act_y = 0; m_fs_cnt = 0; m_prev_vs = 0;
    hist.delete();
    repeat (3) hist.push_back(z);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_en"}, 32'(rom_en), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_hit"}, 32'(hit_out), 0);
    chk({tag, "_rgb"}, 32'(rgb_out), 0);
    chk({tag, "_de"}, 32'(de_out), 0);
    chk({tag, "_hs"}, 32'(hsync_out), 0);
    chk({tag, "_vs"}, 32'(vsync_out), 0);
  endtask

  // One pixel clock: predict from the current inputs, clock, advance model state, then compare.
  task automatic cycle();
    h_t e, o;
    int idx, data;
    bit hit;
    idx   = (m_fs_cnt / 8) % 4;
    e.inb = de_in && pix_x >= m_act_x && pix_x < m_act_x + 32
                  && pix_y >= m_act_y && pix_y < m_act_y + 32;
    e.addr = e.inb ? (idx * 1024 + (pix_y - m_act_y) * 32 + (pix_x - m_act_x)) % 4096 : 0;
    e.de = de_in; e.hs = hsync_in; e.vs = vsync_in;
    hist.push_back(e);
    @(posedge clk); #1;
    if (vsync_in && !m_prev_vs) begin
      m_act_x = pos_we ? int'(pos_x) : m_pend_x;
      m_act_y = pos_we ? int'(pos_y) : m_pend_y;
      if (anim_en) m_fs_cnt++;
    end
    if (pos_we) begin
      m_pend_x = pos_x;
      m_pend_y = pos_y;
    end
    m_prev_vs = vsync_in;
    chk("rom_en", 32'(rom_en), 32'(e.inb));
    chk("rom_addr", 32'(rom_addr), 32'(e.addr));
    o    = hist[hist.size() - 3];
    data = o.inb ? int'(mem[o.addr]) : 0;
    hit  = o.inb && (data != 0);
    chk("hit_out", 32'(hit_out), 32'(hit));
    chk("rgb_out", 32'(rgb_out), hit ? 32'(data) : 0);
    chk("de_out", 32'(de_out), 32'(o.de));
    chk("hsync_out", 32'(hsync_out), 32'(o.hs));
    chk("vsync_out", 32'(vsync_out), 32'(o.vs));
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic frame_pulse();
    vsync_in = 1'b1; de_in = 1'b0; cycle();
    vsync_in = 1'b0; cycle();
  endtask

  task automatic near_pixel();
    pix_x = 10'(m_act_x + $urandom_range(0, 40) - 4);
    pix_y = 10'(m_act_y + $urandom_range(0, 40) - 4);
    de_in = ($urandom_range(0, 7) != 0);
    hsync_in = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
    mem[0]    = 12'h000;
    mem[1]    = 12'hF80;
    mem[1023] = 12'h0A5;
    model_reset();

    // Asynchronous reset holds every output low.
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) cycle();

    // Position load, first pixel and last pixel of frame 0; colour key.
    pos_x = 100; pos_y = 50; pos_we = 1'b1; cycle();
    pos_we = 1'b0;
    frame_pulse();
    pix_x = 100; pix_y = 50; de_in = 1'b1; cycle();
    chk("load_en", 32'(rom_en), 1);
    chk("load_addr0", 32'(rom_addr), 0);
    pix_x = 101; pix_y = 50; cycle();
    chk("load_addr1", 32'(rom_addr), 1);
    pix_x = 131; pix_y = 81; cycle();
    chk("load_addr1023", 32'(rom_addr), 1023);
    chk("transp_hit", 32'(hit_out), 0);
    de_in = 1'b0; pix_x = 0; pix_y = 0; cycle();
    chk("opaque_hit", 32'(hit_out), 1);
    chk("opaque_rgb", 32'(rgb_out), 32'h0F80);
    repeat (3) cycle();

    // Clipping at the bottom-right corner of a 640x480 raster.
    pos_x = 620; pos_y = 470; pos_we = 1'b1; cycle();
    pos_we = 1'b0;
    frame_pulse();
    for (int i = 0; i < 200; i++) begin
      pix_x = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(600, 1023));
      pix_y = 10'($urandom_range(460, 520));
      de_in = 1'b1;
      cycle();
    end

    // Animation stepping, then hold with anim_en low.
    pos_x = 10; pos_y = 10; pos_we = 1'b1; cycle();
    pos_we = 1'b0; anim_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      frame_pulse();
      repeat (3) begin near_pixel(); cycle(); end
    end
    anim_en = 1'b0;
    for (int f = 0; f < 6; f++) begin
      frame_pulse();
      repeat (3) begin near_pixel(); cycle(); end
    end

    // Mid-frame write stays pending; a write on the frame-start cycle applies at once.
    pos_x = 300; pos_y = 200; pos_we = 1'b1; near_pixel(); cycle();
    pos_we = 1'b0;
    repeat (10) begin near_pixel(); cycle(); end
    pos_x = 400; pos_y = 100; pos_we = 1'b1; vsync_in = 1'b1; de_in = 1'b0; cycle();
    pos_we = 1'b0; vsync_in = 1'b0;
    repeat (20) begin near_pixel(); cycle(); end

    // Random traffic: frame starts, writes and animation all mixed.
    for (int i = 0; i < 1500; i++) begin
      near_pixel();
      vsync_in = ($urandom_range(0, 19) == 0);
      pos_we   = ($urandom_range(0, 9) == 0);
      pos_x    = 10'($urandom);
      pos_y    = 10'($urandom);
      anim_en  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    pos_we = 1'b0;

    // Reset during active video, then recovery with vsync already high.
    pix_x = 10'(m_act_x + 1); pix_y = 10'(m_act_y + 1); de_in = 1'b1; hsync_in = 1'b1;
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    vsync_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle();
    vsync_in = 1'b0;
    for (int i = 0; i < 200; i++) begin
      near_pixel();
      vsync_in = ($urandom_range(0, 15) == 0);
      pos_we   = ($urandom_range(0, 7) == 0);
      pos_x    = 10'($urandom_range(0, 700));
      pos_y    = 10'($urandom_range(0, 500));
      anim_en  = 1'b1;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
